// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage: owns the fetch PC, issues sequential
//                memory requests, queues returned words and feeds decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter int          MAX_OUT  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] newPC,
    input  logic        ctrlFetch,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        decode_ready,
    output logic        flush
);

    localparam int               c_QAW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               c_CW       = $clog2(DEPTH + 1);
    localparam int               c_OW       = $clog2(MAX_OUT + 1);
    localparam int               c_TAW      = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [31:0]      c_DEPTH    = 32'(DEPTH);
    localparam logic [31:0]      c_MAX_OUT  = 32'(MAX_OUT);
    localparam logic [c_TAW-1:0] c_TAG_LAST = c_TAW'(MAX_OUT - 1);

    // Architectural and bookkeeping state
    logic [31:0]      r_fetch_pc;
    logic [c_OW-1:0]  r_outstanding;
    logic [c_OW-1:0]  r_drop;
    logic [c_CW-1:0]  r_count;
    logic [c_QAW-1:0] r_q_head;
    logic [c_QAW-1:0] r_q_tail;
    logic [c_TAW-1:0] r_tag_rd;
    logic [c_TAW-1:0] r_tag_wr;
    logic             r_flush;

    // Storage arrays (no reset needed; validity tracked by the counters)
    logic [31:0]      r_q_instr [DEPTH];
    logic [31:0]      r_q_pc    [DEPTH];
    logic [31:0]      r_tag_pc  [MAX_OUT];

    logic [31:0]      w_in_use;
    logic             w_head_valid;
    logic             w_grant;
    logic             w_resp;
    logic             w_dropping;
    logic             w_push;
    logic             w_pop;
    logic [c_OW-1:0]  w_out_next;
    logic             w_unused_newpc_lsbs;

    function automatic logic [c_TAW-1:0] f_tag_next(input logic [c_TAW-1:0] ptr);
        return (ptr == c_TAG_LAST) ? '0 : ptr + c_TAW'(1);
    endfunction

    // Queue slots already spoken for: live (non-dropped) requests plus held words
    assign w_in_use     = 32'(r_outstanding) - 32'(r_drop) + 32'(r_count);
    assign w_head_valid = (r_count != '0);

    assign imem_req  = !reset && !halt && (32'(r_outstanding) < c_MAX_OUT) && (w_in_use < c_DEPTH);
    assign imem_addr = r_fetch_pc;

    assign w_grant    = imem_req && imem_gnt;
    assign w_resp     = imem_rvalid && (r_outstanding != '0);
    assign w_dropping = (r_drop != '0);
    assign w_push     = w_resp && !w_dropping && !ctrlFetch;
    assign w_pop      = instr_valid && decode_ready;
    assign w_out_next = r_outstanding + c_OW'(w_grant) - c_OW'(w_resp);

    assign instr_valid = !reset && w_head_valid && !halt && !r_flush;
    assign instr       = (!reset && w_head_valid) ? r_q_instr[r_q_head] : '0;
    assign instr_pc    = (!reset && w_head_valid) ? r_q_pc[r_q_head]    : '0;
    assign flush       = r_flush && !reset;

    assign w_unused_newpc_lsbs = ^newPC[1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_count       <= '0;
            r_q_head      <= '0;
            r_q_tail      <= '0;
            r_tag_rd      <= '0;
            r_tag_wr      <= '0;
            r_flush       <= 1'b0;
        end else begin
            r_flush       <= ctrlFetch;
            r_outstanding <= w_out_next;
            if (ctrlFetch) begin
                // Every request still in flight after this edge belongs to the old path
                r_fetch_pc <= {newPC[31:2], 2'b00};
                r_drop     <= w_out_next;
                r_count    <= '0;
                r_q_head   <= '0;
                r_q_tail   <= '0;
                r_tag_rd   <= '0;
                r_tag_wr   <= '0;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                    r_tag_wr   <= f_tag_next(r_tag_wr);
                end
                if (w_resp && w_dropping) begin
                    r_drop <= r_drop - c_OW'(1);
                end
                if (w_push) begin
                    r_q_tail <= r_q_tail + c_QAW'(1);
                    r_tag_rd <= f_tag_next(r_tag_rd);
                end
                if (w_pop) begin
                    r_q_head <= r_q_head + c_QAW'(1);
                end
                r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (w_push) begin
                r_q_instr[r_q_tail] <= imem_rdata;
                r_q_pc[r_q_tail]    <= r_tag_pc[r_tag_rd];
            end
            if (w_grant && !ctrlFetch) begin
                r_tag_pc[r_tag_wr] <= r_fetch_pc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit with a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam int          MAX_OUT  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] newPC = '0;
    logic        ctrlFetch = 1'b0;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        decode_ready = 1'b0;
    logic        flush;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clock(clock), .reset(reset), .newPC(newPC), .ctrlFetch(ctrlFetch), .halt(halt),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .decode_ready(decode_ready), .flush(flush)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model: requests owed by memory, and words decode should see
    logic [31:0] m_pc = RESET_PC;
    logic        m_flush = 1'b0;
    logic [31:0] pend_addr[$];
    bit          pend_stale[$];
    logic [31:0] held[$];

    logic        exp_req, exp_valid, exp_flush;
    logic [31:0] exp_addr, exp_pc, exp_instr;
    logic        obs_req, obs_valid, obs_flush;
    logic [31:0] obs_addr, obs_pc, obs_instr;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int live_pend();
        int n = 0;
        foreach (pend_stale[i]) if (!pend_stale[i]) n++;
        return n;
    endfunction

    // One clock: entered and left just after a falling edge
    task automatic cycle();
        logic [31:0] a;
        bit          st;
        imem_rdata = (pend_addr.size() > 0) ? word_of(pend_addr[0]) : $urandom;
        #1;
        exp_req   = !reset && !halt && (pend_addr.size() < MAX_OUT) && (live_pend() + held.size() < DEPTH);
        exp_addr  = m_pc;
        exp_flush = m_flush && !reset;
        exp_valid = !reset && (held.size() > 0) && !halt && !m_flush;
        exp_pc    = (held.size() > 0) ? held[0] : 32'h0;
        exp_instr = word_of(exp_pc);
        obs_req   = imem_req;   obs_addr  = imem_addr; obs_flush = flush;
        obs_valid = instr_valid; obs_pc   = instr_pc;  obs_instr = instr;
        @(posedge clock);
        if (reset) begin
            m_pc = RESET_PC; m_flush = 1'b0;
            pend_addr.delete(); pend_stale.delete(); held.delete();
        end else begin
            if (exp_valid && decode_ready) void'(held.pop_front());
            if (imem_rvalid && pend_addr.size() > 0) begin
                a  = pend_addr.pop_front();
                st = pend_stale.pop_front();
                if (!st && !ctrlFetch) held.push_back(a);
            end
            if (exp_req && imem_gnt) begin
                pend_addr.push_back(m_pc); pend_stale.push_back(1'b0);
                m_pc = m_pc + 32'd4;
            end
            if (ctrlFetch) begin
                held.delete();
                foreach (pend_stale[i]) pend_stale[i] = 1'b1;
                m_pc = {newPC[31:2], 2'b00};
            end
            m_flush = ctrlFetch;
        end
        @(negedge clock);
    endtask

    task automatic drain();
        int k = 0;
        reset = 0; ctrlFetch = 0; halt = 0; imem_gnt = 0; decode_ready = 1;
        while ((pend_addr.size() > 0 || held.size() > 0) && k < 20) begin
            imem_rvalid = (pend_addr.size() > 0);
            cycle();
            k++;
        end
        imem_rvalid = 0;
        n_tests++;
        if (k >= 20) begin
            n_fail++;
            $display("FAIL drain_timeout: pending %0d held %0d after 20 cycles, want 0/0", pend_addr.size(), held.size());
        end
    endtask

    task automatic test_reset();
        reset = 1; ctrlFetch = 0; halt = 0; imem_gnt = 1; imem_rvalid = 0; decode_ready = 1;
        repeat (2) begin
            cycle();
            n_tests++;
            if ({obs_req, obs_valid, obs_flush} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_outputs: req/valid/flush got %b%b%b want 000", obs_req, obs_valid, obs_flush);
            end
        end
        reset = 0; imem_gnt = 0;
        cycle();
        n_tests++;
        if ({obs_req, obs_valid, obs_flush, obs_addr, obs_instr, obs_pc} !== {3'b100, RESET_PC, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_release: req/valid/flush %b%b%b addr %h instr %h pc %h want 100 %h 0 0",
                     obs_req, obs_valid, obs_flush, obs_addr, obs_instr, obs_pc, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        int          first_valid = -1;
        logic [31:0] got[$];
        logic [31:0] want;
        imem_gnt = 1; decode_ready = 1; halt = 0; ctrlFetch = 0;
        for (int k = 0; k < 12; k++) begin
            imem_rvalid = (pend_addr.size() > 0);
            cycle();
            if (obs_valid && first_valid < 0) first_valid = k;
            if (obs_valid && decode_ready) got.push_back(obs_pc);
            n_tests++;
            if ({obs_req, obs_valid, obs_flush, obs_addr} !== {exp_req, exp_valid, exp_flush, exp_addr}) begin
                n_fail++;
                $display("FAIL seq_ctl k=%0d: req/valid/flush/addr got %b%b%b %h want %b%b%b %h",
                         k, obs_req, obs_valid, obs_flush, obs_addr, exp_req, exp_valid, exp_flush, exp_addr);
            end
            if (exp_valid) begin
                n_tests++;
                if ({obs_pc, obs_instr} !== {exp_pc, exp_instr}) begin
                    n_fail++;
                    $display("FAIL seq_data: pc/instr got %h %h want %h %h", obs_pc, obs_instr, exp_pc, exp_instr);
                end
            end
        end
        n_tests++;
        if (first_valid != 2) begin
            n_fail++;
            $display("FAIL seq_latency: first instr_valid at cycle %0d want 2", first_valid);
        end
        for (int i = 0; i < 4; i++) begin
            want = RESET_PC + 32'(4 * i);
            n_tests++;
            if (got.size() <= i || got[i] !== want) begin
                n_fail++;
                $display("FAIL seq_order[%0d]: got %h want %h", i, (got.size() > i) ? got[i] : 32'hx, want);
            end
        end
        imem_rvalid = 0;
    endtask

    task automatic test_backpressure();
        logic [31:0] prev = '0;
        bit          have_prev = 0;
        imem_gnt = 1; decode_ready = 0;
        for (int k = 0; k < 18; k++) begin
            if (k == 6) decode_ready = 1;
            imem_rvalid = (pend_addr.size() > 0);
            cycle();
            n_tests++;
            if ({obs_req, obs_valid, obs_flush, obs_addr} !== {exp_req, exp_valid, exp_flush, exp_addr}) begin
                n_fail++;
                $display("FAIL bp_ctl k=%0d: req/valid/flush/addr got %b%b%b %h want %b%b%b %h",
                         k, obs_req, obs_valid, obs_flush, obs_addr, exp_req, exp_valid, exp_flush, exp_addr);
            end
            if (exp_valid) begin
                n_tests++;
                if ({obs_pc, obs_instr} !== {exp_pc, exp_instr}) begin
                    n_fail++;
                    $display("FAIL bp_data: pc/instr got %h %h want %h %h", obs_pc, obs_instr, exp_pc, exp_instr);
                end
            end
            if (k == 5) begin
                n_tests++;
                if ({obs_req, obs_valid} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL bp_full: req/valid got %b%b want 01", obs_req, obs_valid);
                end
            end
            if (obs_valid && decode_ready) begin
                if (have_prev) begin
                    n_tests++;
                    if (obs_pc !== prev + 32'd4) begin
                        n_fail++;
                        $display("FAIL bp_contig: pc got %h want %h", obs_pc, prev + 32'd4);
                    end
                end
                prev = obs_pc; have_prev = 1;
            end
        end
        imem_rvalid = 0;
    endtask

    task automatic test_redirect();
        logic [31:0] got[$];
        drain();
        ctrlFetch = 1; newPC = 32'h10; imem_gnt = 0;
        cycle();
        ctrlFetch = 0; imem_gnt = 1;
        cycle();
        n_tests++;
        if ({obs_flush, obs_req, obs_addr} !== {2'b11, 32'h10}) begin
            n_fail++;
            $display("FAIL redir_first: flush/req/addr got %b%b %h want 11 00000010", obs_flush, obs_req, obs_addr);
        end
        cycle();
        ctrlFetch = 1; newPC = 32'h200; imem_gnt = 0; imem_rvalid = 1;
        cycle();
        ctrlFetch = 0; imem_gnt = 1; imem_rvalid = 1;
        cycle();
        n_tests++;
        if ({obs_flush, obs_valid, obs_addr} !== {2'b10, 32'h200}) begin
            n_fail++;
            $display("FAIL redir_flush: flush/valid/addr got %b%b %h want 10 00000200", obs_flush, obs_valid, obs_addr);
        end
        for (int k = 0; k < 12; k++) begin
            imem_rvalid = (pend_addr.size() > 0);
            cycle();
            if (obs_valid && decode_ready) got.push_back(obs_pc);
            n_tests++;
            if ({obs_req, obs_valid, obs_flush, obs_addr} !== {exp_req, exp_valid, exp_flush, exp_addr}) begin
                n_fail++;
                $display("FAIL redir_ctl k=%0d: req/valid/flush/addr got %b%b%b %h want %b%b%b %h",
                         k, obs_req, obs_valid, obs_flush, obs_addr, exp_req, exp_valid, exp_flush, exp_addr);
            end
        end
        n_tests++;
        if (got.size() < 2 || got[0] !== 32'h200 || got[1] !== 32'h204) begin
            n_fail++;
            $display("FAIL redir_target: first pcs got %h %h want 00000200 00000204",
                     (got.size() > 0) ? got[0] : 32'hx, (got.size() > 1) ? got[1] : 32'hx);
        end
        imem_rvalid = 0;
    endtask

    task automatic test_align_wrap();
        drain();
        ctrlFetch = 1; newPC = 32'h103;
        cycle();
        ctrlFetch = 0;
        cycle();
        n_tests++;
        if (obs_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL align: addr got %h want 00000100", obs_addr);
        end
        ctrlFetch = 1; newPC = 32'hFFFF_FFFC;
        cycle();
        ctrlFetch = 0; imem_gnt = 1;
        cycle();
        n_tests++;
        if ({obs_req, obs_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_fail++;
            $display("FAIL wrap_top: req/addr got %b %h want 1 fffffffc", obs_req, obs_addr);
        end
        imem_gnt = 0;
        cycle();
        n_tests++;
        if (obs_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_zero: addr got %h want 00000000", obs_addr);
        end
        drain();
    endtask

    task automatic test_halt();
        logic [31:0] granted;
        logic [31:0] got[$];
        drain();
        imem_gnt = 1;
        cycle();
        granted = exp_addr;
        imem_gnt = 0; halt = 1;
        for (int k = 0; k < 3; k++) begin
            imem_rvalid = (k == 0);
            cycle();
            n_tests++;
            if ({obs_valid, obs_req} !== 2'b00) begin
                n_fail++;
                $display("FAIL halt_hold k=%0d: valid/req got %b%b want 00", k, obs_valid, obs_req);
            end
        end
        imem_rvalid = 0; halt = 0; decode_ready = 1;
        cycle();
        n_tests++;
        if ({obs_valid, obs_pc, obs_instr} !== {1'b1, granted, word_of(granted)}) begin
            n_fail++;
            $display("FAIL halt_release: valid/pc/instr got %b %h %h want 1 %h %h",
                     obs_valid, obs_pc, obs_instr, granted, word_of(granted));
        end
        halt = 1; ctrlFetch = 1; newPC = 32'h300;
        cycle();
        ctrlFetch = 0;
        cycle();
        n_tests++;
        if ({obs_flush, obs_req, obs_valid, obs_addr} !== {3'b100, 32'h300}) begin
            n_fail++;
            $display("FAIL halt_redir: flush/req/valid/addr got %b%b%b %h want 100 00000300",
                     obs_flush, obs_req, obs_valid, obs_addr);
        end
        halt = 0; imem_gnt = 1;
        for (int k = 0; k < 8; k++) begin
            imem_rvalid = (pend_addr.size() > 0);
            cycle();
            if (obs_valid && decode_ready) got.push_back(obs_pc);
        end
        n_tests++;
        if (got.size() < 1 || got[0] !== 32'h300) begin
            n_fail++;
            $display("FAIL halt_redir_first: pc got %h want 00000300", (got.size() > 0) ? got[0] : 32'hx);
        end
        imem_rvalid = 0;
    endtask

    task automatic test_reset_midflight();
        logic [31:0] got[$];
        drain();
        imem_gnt = 1;
        repeat (2) cycle();
        imem_gnt = 0; reset = 1;
        repeat (2) cycle();
        reset = 0; imem_rvalid = 1;
        for (int k = 0; k < 2; k++) begin
            cycle();
            n_tests++;
            if (obs_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stale_resp k=%0d: valid got %b want 0", k, obs_valid);
            end
        end
        imem_gnt = 1; decode_ready = 1;
        for (int k = 0; k < 10; k++) begin
            imem_rvalid = (pend_addr.size() > 0);
            cycle();
            if (obs_valid && decode_ready) got.push_back(obs_pc);
        end
        n_tests++;
        if (got.size() < 1 || got[0] !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_first_pc: pc got %h want %h", (got.size() > 0) ? got[0] : 32'hx, RESET_PC);
        end
        imem_rvalid = 0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            reset        = ($urandom_range(99) < 1);
            ctrlFetch    = ($urandom_range(99) < 5);
            newPC        = $urandom;
            halt         = ($urandom_range(99) < 10);
            imem_gnt     = ($urandom_range(99) < 70);
            decode_ready = ($urandom_range(99) < 70);
            imem_rvalid  = (pend_addr.size() > 0) ? ($urandom_range(99) < 60) : ($urandom_range(99) < 5);
            cycle();
            n_tests++;
            if ({obs_req, obs_valid, obs_flush, obs_addr} !== {exp_req, exp_valid, exp_flush, exp_addr}) begin
                n_fail++;
                $display("FAIL rand_ctl k=%0d: req/valid/flush/addr got %b%b%b %h want %b%b%b %h",
                         k, obs_req, obs_valid, obs_flush, obs_addr, exp_req, exp_valid, exp_flush, exp_addr);
            end
            if (exp_valid) begin
                n_tests++;
                if ({obs_pc, obs_instr} !== {exp_pc, exp_instr}) begin
                    n_fail++;
                    $display("FAIL rand_data k=%0d: pc/instr got %h %h want %h %h", k, obs_pc, obs_instr, exp_pc, exp_instr);
                end
            end
        end
        reset = 0; ctrlFetch = 0; halt = 0; imem_gnt = 0; imem_rvalid = 0;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            assert (dut.r_drop <= dut.r_outstanding && dut.r_outstanding <= MAX_OUT && dut.r_count <= DEPTH)
            else begin
                n_fail++;
                $display("FAIL invariant: drop %0d outstanding %0d count %0d", dut.r_drop, dut.r_outstanding, dut.r_count);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clock);
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_align_wrap();
        test_halt();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
